// File: rtl/axil_cfg_writer.sv
// Turns one (addr, data, strb) command into a single AXI4-Lite write, one at a time.
// A saturating watchdog flags transactions whose B response takes too long.
module axil_cfg_writer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [3:0]        cmd_strb,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              done_valid_q, done_valid_d;
  logic [1:0]        done_resp_q, done_resp_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  logic cmd_fire, aw_hs, w_hs, b_hs, aw_all, w_all;

  // Held low during reset; also held off for the done_valid cycle so a new
  // command is only taken the cycle after completion is reported.
  assign cmd_ready = rstn && (state_q == S_IDLE) && !done_valid_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid_q && m_axi_awready;
  assign w_hs      = wvalid_q && m_axi_wready;
  assign b_hs      = bready_q && m_axi_bvalid;
  assign aw_all    = aw_done_q || aw_hs;
  assign w_all     = w_done_q || w_hs;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_fire)        state_d = S_ISSUE;
      S_ISSUE: if (aw_all && w_all) state_d = S_RESP;
      S_RESP:  if (b_hs)            state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    done_valid_d = 1'b0;
    done_resp_d  = done_resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_data;
          wstrb_d   = cmd_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_all && w_all) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_RESP: begin
        if (b_hs) begin
          bready_d     = 1'b0;
          done_valid_d = 1'b1;
          done_resp_d  = m_axi_bresp;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // Watchdog: counts every busy cycle, saturates at TIMEOUT; clear beats set.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT_C) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == TIMEOUT_C) err_d = 1'b1;
    end
    if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= 2'b00;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign done_valid    = done_valid_q;
  assign done_resp     = done_resp_q;
  assign err_timeout   = err_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axil_cfg_writer.sv
// Bench for axil_cfg_writer: configurable-latency AXI4-Lite write slave, protocol
// monitor and an in-order expected queue of writes and responses.
module tb_axil_cfg_writer;

  localparam int TB_TIMEOUT = 1023;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        err_timeout;
  logic        err_clr = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  axil_cfg_writer #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .done_valid(done_valid), .done_resp(done_resp), .err_timeout(err_timeout),
    .err_clr(err_clr), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard: expected writes {addr, strb, data} and responses, in issue order
  logic [67:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  logic [31:0] cap_aw[$];
  logic [35:0] cap_w[$];
  logic [1:0]  done_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int proto_viol = 0;
  int dbl_pulse = 0;

  // Slave configuration, written only by the stimulus block
  int         aw_delay = 0;
  int         w_delay = 0;
  int         b_delay = 0;
  logic [1:0] b_resp_cfg = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: samples handshakes at the edge, drives its outputs 1 time unit later
  int   aw_wait = 0, w_wait = 0, b_wait = 0;
  logic aw_seen = 1'b0, w_seen = 1'b0, b_pend = 1'b0;
  logic aw_hs, w_hs, b_hs;
  always begin : axi_slave
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0;
    end else begin
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if (aw_hs) begin cap_aw.push_back(m_axi_awaddr); aw_seen = 1'b1; end
      if (w_hs) begin cap_w.push_back({m_axi_wstrb, m_axi_wdata}); w_seen = 1'b1; end
      if (aw_seen && w_seen) begin b_pend = 1'b1; b_wait = 0; aw_seen = 1'b0; w_seen = 1'b0; end
      #1;
      if (rstn) begin
        if (b_hs) m_axi_bvalid = 1'b0;
        if (m_axi_awvalid && !aw_hs) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
        else begin m_axi_awready = 1'b0; aw_wait = 0; end
        if (m_axi_wvalid && !w_hs) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
        else begin m_axi_wready = 1'b0; w_wait = 0; end
        if (b_pend && !m_axi_bvalid) begin
          if (b_wait >= b_delay) begin
            m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_cfg; b_pend = 1'b0;
          end else b_wait++;
        end
      end
    end
  end

  // Monitor: done pulses, valid/payload stability, joint AW/W start, cmd_ready vs busy
  logic p_aw = 1'b0, p_awr = 1'b0, p_w = 1'b0, p_wr = 1'b0, p_done = 1'b0;
  logic [31:0] p_addr = '0;
  logic [35:0] p_wpay = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      p_aw = 1'b0; p_awr = 1'b0; p_w = 1'b0; p_wr = 1'b0; p_done = 1'b0;
    end else begin
      if (done_valid) begin
        done_q.push_back(done_resp);
        if (p_done) dbl_pulse++;
      end
      if (p_aw && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_addr)) proto_viol++;
      if (p_w && !p_wr && (!m_axi_wvalid || {m_axi_wstrb, m_axi_wdata} != p_wpay)) proto_viol++;
      if (!p_aw && !p_w && (m_axi_awvalid != m_axi_wvalid)) proto_viol++;
      if (busy && cmd_ready) proto_viol++;
      p_aw = m_axi_awvalid; p_awr = m_axi_awready; p_addr = m_axi_awaddr;
      p_w = m_axi_wvalid; p_wr = m_axi_wready; p_wpay = {m_axi_wstrb, m_axi_wdata};
      p_done = done_valid;
    end
  end

  // Driver tasks
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r);
    exp_q.push_back({a, s, d});
    exp_resp_q.push_back(r);
  endtask

  // Returns 1 time unit after the accepting edge
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    check("done_seen", {63'd0, done_valid}, 64'd1);
  endtask

  task automatic set_slave(input int a, input int w, input int b, input logic [1:0] r);
    aw_delay = a; w_delay = w; b_delay = b; b_resp_cfg = r;
  endtask

  initial begin : stimulus
    int lat, n, base;
    logic [31:0] ra, rd;
    logic [3:0]  rs;
    logic [1:0]  rr;
    logic [31:0] t3_addr[3];
    logic [31:0] t3_data[3];
    t3_addr[0] = 32'h4; t3_addr[1] = 32'h8; t3_addr[2] = 32'hC;
    t3_data[0] = 32'hAABB_CCDD; t3_data[1] = 32'h0011_2233; t3_data[2] = 32'h0044_5566;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
    check("rst_wvalid", {63'd0, m_axi_wvalid}, 64'd0);
    check("rst_bready", {63'd0, m_axi_bready}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_done_valid", {63'd0, done_valid}, 64'd0);
    check("rst_done_resp", {62'd0, done_resp}, 64'd0);
    check("rst_err", {63'd0, err_timeout}, 64'd0);
    check("rst_awaddr", {32'd0, m_axi_awaddr}, 64'd0);
    check("rst_wdata", {32'd0, m_axi_wdata}, 64'd0);
    check("rst_wstrb", {60'd0, m_axi_wstrb}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Zero-wait slave
    set_slave(0, 0, 0, 2'b00);
    expect_write(32'h0, 32'h0001_2345, 4'hF, 2'b00);
    send_cmd(32'h0, 32'h0001_2345, 4'hF);
    check("t1_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
    check("t1_wvalid", {63'd0, m_axi_wvalid}, 64'd1);
    check("t1_awaddr", {32'd0, m_axi_awaddr}, 64'h0);
    check("t1_wdata", {32'd0, m_axi_wdata}, 64'h12345);
    check("t1_wstrb", {60'd0, m_axi_wstrb}, 64'hF);
    check("t1_awprot", {61'd0, m_axi_awprot}, 64'd0);
    check("t1_bready", {63'd0, m_axi_bready}, 64'd0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    wait_done(lat);
    // lat counts edges after the one following acceptance
    check("t1_accept_to_done", 64'(lat + 1), 64'd3);
    check("t1_done_resp", {62'd0, done_resp}, 64'd0);
    check("t1_cmd_ready_in_done", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    check("t1_done_pulse_end", {63'd0, done_valid}, 64'd0);
    check("t1_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);

    // AW ready delayed, W ready immediate
    set_slave(3, 0, 0, 2'b00);
    base = done_q.size();
    expect_write(32'h4, 32'hCAFE_0004, 4'h3, 2'b00);
    send_cmd(32'h4, 32'hCAFE_0004, 4'h3);
    n = 0;
    while (m_axi_awvalid && n < 50) begin
      n++;
      @(posedge clk); #1;
      if (n == 1) check("t2_wvalid_dropped", {63'd0, m_axi_wvalid}, 64'd0);
    end
    check("t2_aw_hold_cycles", 64'(n), 64'd4);
    wait_done(lat);
    repeat (5) @(posedge clk);
    #1;
    check("t2_one_b", 64'(done_q.size() - base), 64'd1);

    // Three back-to-back commands
    set_slave(0, 0, 1, 2'b00);
    base = done_q.size();
    for (int i = 0; i < 3; i++) begin
      expect_write(t3_addr[i], t3_data[i], 4'hF, 2'b00);
      send_cmd(t3_addr[i], t3_data[i], 4'hF);
      check("t3_busy_after_accept", {63'd0, busy}, 64'd1);
      check("t3_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    end
    n = 0;
    while (done_q.size() < base + 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("t3_done_count", 64'(done_q.size() - base), 64'd3);

    // Withheld B response drives the watchdog
    set_slave(0, 0, 1100, 2'b00);
    expect_write(32'h0, 32'h0000_0101, 4'hF, 2'b00);
    send_cmd(32'h0, 32'h0000_0101, 4'hF);
    repeat (TB_TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_err_before", {63'd0, err_timeout}, 64'd0);
    @(posedge clk); #1;
    check("to_err_set", {63'd0, err_timeout}, 64'd1);
    check("to_still_busy", {63'd0, busy}, 64'd1);
    wait_done(lat);
    check("to_err_sticky", {63'd0, err_timeout}, 64'd1);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    check("to_err_cleared", {63'd0, err_timeout}, 64'd0);

    // Clear held across the setting edge wins, and saturation prevents a re-set
    set_slave(0, 0, 1050, 2'b00);
    expect_write(32'h8, 32'h0000_0202, 4'hF, 2'b00);
    send_cmd(32'h8, 32'h0000_0202, 4'hF);
    repeat (TB_TIMEOUT - 3) @(posedge clk);
    #1 err_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_prio", {63'd0, err_timeout}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("clr_no_reset_after_sat", {63'd0, err_timeout}, 64'd0);
    wait_done(lat);

    // Error response
    set_slave(0, 0, 0, 2'b10);
    expect_write(32'hC, 32'h0000_0303, 4'h1, 2'b10);
    send_cmd(32'hC, 32'h0000_0303, 4'h1);
    wait_done(lat);
    check("slverr_resp", {62'd0, done_resp}, 64'h2);
    @(posedge clk); #1;
    check("slverr_idle", {63'd0, busy}, 64'd0);
    check("slverr_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("slverr_resp_held", {62'd0, done_resp}, 64'h2);

    // Reset while in ISSUE; the aborted command is not expected anywhere
    set_slave(5, 5, 0, 2'b00);
    send_cmd(32'h4, 32'hDEAD_BEEF, 4'hF);
    check("rst_mid_pre_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    check("rst_mid_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
    check("rst_mid_wvalid", {63'd0, m_axi_wvalid}, 64'd0);
    check("rst_mid_bready", {63'd0, m_axi_bready}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    set_slave(0, 0, 0, 2'b00);
    expect_write(32'h4, 32'h1234_5678, 4'hF, 2'b00);
    send_cmd(32'h4, 32'h1234_5678, 4'hF);
    wait_done(lat);
    check("rst_after_resp", {62'd0, done_resp}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      ra = 32'($urandom_range(0, 3)) << 2;
      rd = $urandom;
      rs = 4'($urandom_range(1, 15));
      rr = 2'($urandom_range(0, 3));
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rr);
      expect_write(ra, rd, rs, rr);
      send_cmd(ra, rd, rs);
      wait_done(lat);
      check("rand_resp", {62'd0, done_resp}, {62'd0, rr});
    end
    repeat (4) @(posedge clk);
    #1;

    // Scoreboard drain
    check("sb_aw_count", 64'(cap_aw.size()), 64'(exp_q.size()));
    check("sb_w_count", 64'(cap_w.size()), 64'(exp_q.size()));
    check("sb_done_count", 64'(done_q.size()), 64'(exp_resp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_aw.size()) check("sb_awaddr", {32'd0, cap_aw[i]}, {32'd0, exp_q[i][67:36]});
      if (i < cap_w.size()) check("sb_wpayload", {28'd0, cap_w[i]}, {28'd0, exp_q[i][35:0]});
      if (i < done_q.size()) check("sb_resp", {62'd0, done_q[i]}, {62'd0, exp_resp_q[i]});
    end
    check("protocol_violations", 64'(proto_viol), 64'd0);
    check("done_double_pulse", 64'(dbl_pulse), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
